// File: rtl/lock_code_sender_pkg.sv
// Shared definitions for the one-hot button-code interface between the
// code sender and the combination-lock FSM: button codes and state encoding.
package lock_code_sender_pkg;

    // One-hot button codes as seen on the lock's din bus
    localparam logic [3:0] B0 = 4'b0001;
    localparam logic [3:0] B1 = 4'b0010;
    localparam logic [3:0] B2 = 4'b0100;
    localparam logic [3:0] B3 = 4'b1000;

    // Sender FSM state encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND_SEQ  = 2'd1;
    localparam logic [1:0] ST_SEND_LOCK = 2'd2;
    localparam logic [1:0] ST_FINISH    = 2'd3;

    // A zero step code marks the end of a shortened unlock sequence
    function automatic logic is_end_code(input logic [3:0] code);
        return (code == 4'b0000);
    endfunction

endpackage

// File: rtl/lock_code_sender_hold.sv
// hold_timer: down-counter that measures how long one code stays on din.
// Loading sets it to HOLD_CYCLES-1; expire is high during the last hold cycle.
module hold_timer #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Reload on each new code, otherwise count down and rest at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= CNT_ZERO;
        end else if (i_load) begin
            r_cnt <= CNT_RELOAD;
        end else if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == CNT_ZERO);

endmodule

// File: rtl/lock_code_sender.sv
// lock_code_sender: plays a stored unlock sequence, or the single lock code
// B0, onto the lock's one-hot din bus. Codes abut with no zero gap because the
// lock drops back to idle whenever din is zero. All outputs are registered.
module lock_code_sender
    import lock_code_sender_pkg::*;
#(
    parameter int STEPS       = 3,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1),
    localparam int IDX_W      = $clog2(STEPS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_lock_req,
    input  logic [4*STEPS-1:0]   i_code_seq,
    output logic [3:0]           o_din,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [IDX_W-1:0]     o_step_idx
);

    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS - 1);

    // Registered state; r_seq holds the codes still to be sent after the
    // one currently on din, next code in bits [3:0].
    logic [1:0]           r_state;
    logic [3:0]           r_din;
    logic                 r_busy;
    logic                 r_done;
    logic [IDX_W-1:0]     r_idx;
    logic [4*STEPS-1:0]   r_seq;

    logic [1:0]           w_state;
    logic [3:0]           w_din;
    logic                 w_busy;
    logic                 w_done;
    logic [IDX_W-1:0]     w_idx;
    logic [4*STEPS-1:0]   w_seq;
    logic                 w_load;
    logic                 w_expire;

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .o_expire (w_expire)
    );

    // Next-state and next-output logic; outputs are computed for the coming
    // cycle so that the registers present them without an extra delay
    always_comb begin
        w_state = r_state;
        w_din   = r_din;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_idx   = r_idx;
        w_seq   = r_seq;
        w_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_din  = 4'b0000;
                w_busy = 1'b0;
                w_idx  = IDX_ZERO;
                if (i_lock_req) begin
                    // lock_req beats a simultaneous start
                    w_state = ST_SEND_LOCK;
                    w_din   = B0;
                    w_busy  = 1'b1;
                    w_load  = 1'b1;
                end else if (i_start) begin
                    w_seq = i_code_seq >> 4'd4;
                    if (is_end_code(i_code_seq[3:0])) begin
                        // empty sequence: nothing to drive, report done
                        w_state = ST_FINISH;
                        w_done  = 1'b1;
                    end else begin
                        w_state = ST_SEND_SEQ;
                        w_din   = i_code_seq[3:0];
                        w_busy  = 1'b1;
                        w_load  = 1'b1;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SEND_SEQ: begin
                if (w_expire) begin
                    if ((r_idx == IDX_LAST) || is_end_code(r_seq[3:0])) begin
                        w_state = ST_FINISH;
                        w_din   = 4'b0000;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_idx   = IDX_ZERO;
                    end else begin
                        // next step abuts the current one on din
                        w_din  = r_seq[3:0];
                        w_seq  = r_seq >> 4'd4;
                        w_idx  = r_idx + IDX_ONE;
                        w_load = 1'b1;
                    end
                end else begin
                    w_state = ST_SEND_SEQ;
                end
            end
            ST_SEND_LOCK: begin
                if (w_expire) begin
                    w_state = ST_FINISH;
                    w_din   = 4'b0000;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_idx   = IDX_ZERO;
                end else begin
                    w_state = ST_SEND_LOCK;
                end
            end
            ST_FINISH: begin
                w_state = ST_IDLE;
                w_din   = 4'b0000;
                w_busy  = 1'b0;
                w_idx   = IDX_ZERO;
            end
            default: begin
                w_state = ST_IDLE;
                w_din   = 4'b0000;
                w_busy  = 1'b0;
                w_idx   = IDX_ZERO;
                w_seq   = '0;
            end
        endcase
    end

    // State and output registers; reset clears din without waiting for a clock
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_din   <= 4'b0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= IDX_ZERO;
            r_seq   <= '0;
        end else begin
            r_state <= w_state;
            r_din   <= w_din;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_idx   <= w_idx;
            r_seq   <= w_seq;
        end
    end

    assign o_din      = r_din;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_step_idx = r_idx;

endmodule

// File: tb/tb_lock_code_sender.sv
// Self-checking bench for lock_code_sender with STEPS=3, HOLD_CYCLES=4.
// Expected per-cycle outputs come from a transaction-level model that expands
// a request into the list of codes it should produce.
module tb_lock_code_sender;

    localparam int STEPS = 3;
    localparam int HOLD  = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        lock_req;
    logic [11:0] code_seq;
    logic [3:0]  din;
    logic        busy;
    logic        done;
    logic [1:0]  step_idx;

    logic [7:0]  exp_q[$];
    int          n_vec;
    int          n_err;

    lock_code_sender #(
        .STEPS       (STEPS),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_lock_req (lock_req),
        .i_code_seq (code_seq),
        .o_din      (din),
        .o_busy     (busy),
        .o_done     (done),
        .o_step_idx (step_idx)
    );

    wire [7:0] obs = {din, busy, done, step_idx};

    always #5 clk = ~clk;

    // Model: expand one accepted request into per-cycle {din,busy,done,idx},
    // starting with the cycle after the request edge, plus one idle cycle.
    task automatic build_exp(input bit is_lock, input logic [11:0] seq);
        logic [3:0] c;
        bit         stop;
        exp_q.delete();
        stop = 1'b0;
        if (is_lock) begin
            for (int h = 0; h < HOLD; h++) exp_q.push_back({4'b0001, 1'b1, 1'b0, 2'd0});
        end else begin
            for (int s = 0; s < STEPS; s++) begin
                c = seq[4*s +: 4];
                if (c == 4'b0000) stop = 1'b1;
                if (!stop) begin
                    for (int h = 0; h < HOLD; h++) exp_q.push_back({c, 1'b1, 1'b0, 2'(s)});
                end
            end
        end
        exp_q.push_back({4'b0000, 1'b0, 1'b1, 2'd0});
        exp_q.push_back(8'h00);
    endtask

    task automatic pulse(input bit s, input bit l, input logic [11:0] seq);
        @(negedge clk);
        start    = s;
        lock_req = l;
        code_seq = seq;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lock_req = 1'b0;
    endtask

    function automatic logic [11:0] rand_seq();
        logic [11:0] q;
        int          p;
        for (int s = 0; s < STEPS; s++) begin
            p = $urandom_range(0, 7);
            if (p < 4)       q[4*s +: 4] = 4'(1 << p);
            else if (p == 4) q[4*s +: 4] = 4'b0000;
            else if (p == 5) q[4*s +: 4] = 4'($urandom);
            else             q[4*s +: 4] = 4'(1 << $urandom_range(0, 3));
        end
        return q;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        #12;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", obs, 8'h00);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL reset_idle got=%h exp=%h", obs, 8'h00);
        end
    endtask

    task automatic test_unlock();
        build_exp(1'b0, 12'h842);
        pulse(1'b1, 1'b0, 12'h842);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_vec++;
            if (obs !== exp_q[c]) begin
                n_err++;
                $display("FAIL unlock cyc%0d got=%h exp=%h", c + 1, obs, exp_q[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_lock();
        build_exp(1'b1, 12'h000);
        pulse(1'b0, 1'b1, 12'h000);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_vec++;
            if (obs !== exp_q[c]) begin
                n_err++;
                $display("FAIL lock cyc%0d got=%h exp=%h", c + 1, obs, exp_q[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_early_end();
        build_exp(1'b0, 12'h042);
        pulse(1'b1, 1'b0, 12'h042);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_vec++;
            if (obs !== exp_q[c]) begin
                n_err++;
                $display("FAIL early_end cyc%0d got=%h exp=%h", c + 1, obs, exp_q[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_simultaneous();
        logic [11:0] seq;
        seq = 12'h428;
        build_exp(1'b1, seq);
        pulse(1'b1, 1'b1, seq);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_vec++;
            if (obs !== exp_q[c]) begin
                n_err++;
                $display("FAIL simultaneous cyc%0d got=%h exp=%h", c + 1, obs, exp_q[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Requests during a send and during FINISH must be dropped
    task automatic test_busy_requests();
        build_exp(1'b0, 12'h842);
        pulse(1'b1, 1'b0, 12'h842);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_vec++;
            if (obs !== exp_q[c]) begin
                n_err++;
                $display("FAIL busy_req cyc%0d got=%h exp=%h", c + 1, obs, exp_q[c]);
            end
            start    = (c == 5) || (c == 12);
            lock_req = (c == 9);
            code_seq = 12'($urandom);
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        lock_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [11:0] seq;
        pulse(1'b1, 1'b0, 12'h842);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid got=%h exp=%h", obs, 8'h00);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seq = 12'h184;
        build_exp(1'b0, seq);
        pulse(1'b1, 1'b0, seq);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_vec++;
            if (obs !== exp_q[c]) begin
                n_err++;
                $display("FAIL after_reset cyc%0d got=%h exp=%h", c + 1, obs, exp_q[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int          kind;
        logic [11:0] seq;
        for (int t = 0; t < 20; t++) begin
            kind = $urandom_range(0, 2);
            seq  = rand_seq();
            build_exp(kind != 0, seq);
            pulse(kind != 1, kind != 0, seq);
            for (int c = 0; c < exp_q.size(); c++) begin
                n_vec++;
                if (obs !== exp_q[c]) begin
                    n_err++;
                    $display("FAIL random t%0d seq=%h cyc%0d got=%h exp=%h",
                             t, seq, c + 1, obs, exp_q[c]);
                end
                @(posedge clk);
                #1;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        lock_req = 1'b0;
        code_seq = 12'h000;
        n_vec    = 0;
        n_err    = 0;
        test_reset();
        test_unlock();
        test_lock();
        test_early_end();
        test_simultaneous();
        test_busy_requests();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
